// File: rtl/bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : bht_predictor
// Brief    : Table of saturating taken/not-taken counters. It is queried with a
//            fetch PC and trained by resolved branches, in bimodal or gshare mode.
// Revision : 1.0
// ============================================================================
module bht_predictor #(
    parameter int INDEX_W  = 8,
    parameter int CTR_W    = 2,
    parameter int INIT_VAL = 1,
    parameter int PC_LSB   = 2,
    parameter int GSHARE   = 0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               query_valid,
    input  logic [31:0]        query_pc,
    output logic               predict_valid,
    output logic               predict_taken,
    output logic [INDEX_W-1:0] predict_idx,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_idx,
    input  logic               update_taken
);

    localparam int               c_ENTRIES = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] c_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ZERO    = '0;
    localparam logic [CTR_W-1:0] c_INIT    = CTR_W'(INIT_VAL);

    logic [CTR_W-1:0]   r_ctr_q [c_ENTRIES];
    logic [CTR_W-1:0]   w_ctr_d [c_ENTRIES];
    logic [INDEX_W-1:0] r_ghr_q, w_ghr_d;
    logic               r_pvalid_q, w_pvalid_d;
    logic               r_ptaken_q, w_ptaken_d;
    logic [INDEX_W-1:0] r_pidx_q, w_pidx_d;

    logic [INDEX_W-1:0] w_query_idx;
    logic [CTR_W-1:0]   w_upd_old;
    logic [CTR_W-1:0]   w_upd_new;
    logic               w_unused_pc;

    // The history seen by a query is the value before this cycle's shift.
    assign w_query_idx = (GSHARE != 0) ? (query_pc[PC_LSB +: INDEX_W] ^ r_ghr_q)
                                       : query_pc[PC_LSB +: INDEX_W];
    assign w_unused_pc = ^query_pc;

    assign w_upd_old = r_ctr_q[update_idx];

    always_comb begin
        w_upd_new = w_upd_old;
        if (update_taken) begin
            if (w_upd_old != c_MAX) begin
                w_upd_new = w_upd_old + CTR_W'(1);
            end
        end else begin
            if (w_upd_old != c_ZERO) begin
                w_upd_new = w_upd_old - CTR_W'(1);
            end
        end
    end

    always_comb begin
        w_ctr_d    = r_ctr_q;
        w_ghr_d    = r_ghr_q;
        w_pvalid_d = r_pvalid_q;
        w_ptaken_d = r_ptaken_q;
        w_pidx_d   = r_pidx_q;
        if (rdy_in) begin
            // The prediction reads r_ctr_q, so a same-cycle update is not bypassed.
            w_pvalid_d = query_valid;
            if (query_valid) begin
                w_ptaken_d = r_ctr_q[w_query_idx][CTR_W-1];
                w_pidx_d   = w_query_idx;
            end
            if (update_valid) begin
                w_ctr_d[update_idx] = w_upd_new;
                if (GSHARE != 0) begin
                    w_ghr_d = {r_ghr_q[INDEX_W-2:0], update_taken};
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_ctr_q[i] <= c_INIT;
            end
            r_ghr_q    <= '0;
            r_pvalid_q <= 1'b0;
            r_ptaken_q <= 1'b0;
            r_pidx_q   <= '0;
        end else begin
            r_ctr_q    <= w_ctr_d;
            r_ghr_q    <= w_ghr_d;
            r_pvalid_q <= w_pvalid_d;
            r_ptaken_q <= w_ptaken_d;
            r_pidx_q   <= w_pidx_d;
        end
    end

    assign predict_valid = r_pvalid_q;
    assign predict_taken = r_ptaken_q;
    assign predict_idx   = r_pidx_q;

endmodule
`default_nettype wire

// File: tb/tb_bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_predictor
// Brief    : Self-checking bench for bht_predictor, with bimodal and gshare instances.
// Revision : 1.0
// ============================================================================
module tb_bht_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        query_valid = 1'b0;
    logic [31:0] query_pc = '0;
    logic        update_valid = 1'b0;
    logic [7:0]  update_idx = '0;
    logic        update_taken = 1'b0;

    logic       pv_a, pt_a, pv_b, pt_b;
    logic [7:0] pi_a, pi_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counters as plain integers, history as an integer.
    int ctr_a [256];
    int ctr_b [256];
    int ghr_b;
    int m_v_a, m_t_a, m_i_a, m_v_b, m_t_b, m_i_b;

    typedef struct {
        bit qv;
        bit uv;
        bit ut;
        bit ev;
        bit et;
    } vec_t;
    vec_t tbl[$];

    always #5 clk_in = ~clk_in;

    bht_predictor #(.INDEX_W(8), .CTR_W(2), .INIT_VAL(1), .PC_LSB(2), .GSHARE(0)) u_bimodal (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .query_valid(query_valid), .query_pc(query_pc),
        .predict_valid(pv_a), .predict_taken(pt_a), .predict_idx(pi_a),
        .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
    );

    bht_predictor #(.INDEX_W(8), .CTR_W(2), .INIT_VAL(1), .PC_LSB(2), .GSHARE(1)) u_gshare (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .query_valid(query_valid), .query_pc(query_pc),
        .predict_valid(pv_b), .predict_taken(pt_b), .predict_idx(pi_b),
        .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            ctr_a[i] = 1;
            ctr_b[i] = 1;
        end
        ghr_b = 0;
        m_v_a = 0; m_t_a = 0; m_i_a = 0;
        m_v_b = 0; m_t_b = 0; m_i_b = 0;
    endtask

    task automatic check_model();
        chk("bim_valid", int'(pv_a), m_v_a);
        chk("bim_taken", int'(pt_a), m_t_a);
        chk("bim_idx",   int'(pi_a), m_i_a);
        chk("gsh_valid", int'(pv_b), m_v_b);
        chk("gsh_taken", int'(pt_b), m_t_b);
        chk("gsh_idx",   int'(pi_b), m_i_b);
    endtask

    // Async reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        chk("rst_valid_a", int'(pv_a), 0);
        chk("rst_taken_a", int'(pt_a), 0);
        chk("rst_idx_a",   int'(pi_a), 0);
        chk("rst_valid_b", int'(pv_b), 0);
        rst_in = 1'b0;
    endtask

    // Drive one cycle, advance the model at the edge, then compare after it.
    task automatic step(input bit rdy, input bit qv, input logic [31:0] pc,
                        input bit uv, input int uidx, input bit ut);
        int ia, ib, na, nb;
        rdy_in       = rdy;
        query_valid  = qv;
        query_pc     = pc;
        update_valid = uv;
        update_idx   = 8'(uidx);
        update_taken = ut;
        @(posedge clk_in);
        if (rdy) begin
            ia = (pc >> 2) % 256;
            ib = ia ^ ghr_b;
            m_v_a = qv;
            m_v_b = qv;
            if (qv) begin
                m_t_a = (ctr_a[ia] >= 2) ? 1 : 0;
                m_i_a = ia;
                m_t_b = (ctr_b[ib] >= 2) ? 1 : 0;
                m_i_b = ib;
            end
            if (uv) begin
                na = ut ? ctr_a[uidx] + 1 : ctr_a[uidx] - 1;
                nb = ut ? ctr_b[uidx] + 1 : ctr_b[uidx] - 1;
                ctr_a[uidx] = (na > 3) ? 3 : ((na < 0) ? 0 : na);
                ctr_b[uidx] = (nb > 3) ? 3 : ((nb < 0) ? 0 : nb);
                ghr_b = ((ghr_b * 2) + (ut ? 1 : 0)) % 256;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        bit v_hold, t_hold;
        int i_hold;

        // pc 0x100 -> index 0x40; updates always target 0x40.
        tbl.push_back(vec_t'{1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1, 1});
        for (int k = 0; k < 5; k++) tbl.push_back(vec_t'{0, 1, 1, 0, 1});
        tbl.push_back(vec_t'{1, 0, 0, 1, 1});
        tbl.push_back(vec_t'{0, 1, 0, 0, 1});
        tbl.push_back(vec_t'{1, 0, 0, 1, 1});
        tbl.push_back(vec_t'{0, 1, 0, 0, 1});
        tbl.push_back(vec_t'{0, 1, 0, 0, 1});
        tbl.push_back(vec_t'{1, 0, 0, 1, 0});
        for (int k = 0; k < 5; k++) tbl.push_back(vec_t'{0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 0, 0});
        tbl.push_back(vec_t'{1, 1, 1, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1, 1});

        model_reset();
        #3;
        chk("init_valid", int'(pv_a), 0);
        rst_in = 1'b0;
        #3;

        // Every index starts weakly not-taken.
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 32'(i * 4), 0, 0, 0);
            chk("sweep_taken", int'(pt_a), 0);
        end
        step(1, 0, 32'h0, 0, 0, 0);
        chk("sweep_valid_drop", int'(pv_a), 0);

        for (int r = 0; r < tbl.size(); r++) begin
            step(1, tbl[r].qv, 32'h100, tbl[r].uv, 'h40, tbl[r].ut);
            chk($sformatf("tbl%0d_valid", r), int'(pv_a), int'(tbl[r].ev));
            chk($sformatf("tbl%0d_taken", r), int'(pt_a), int'(tbl[r].et));
        end

        // gshare: two taken updates give history 0x03.
        do_reset();
        step(1, 0, 32'h0, 1, 'h00, 1);
        step(1, 0, 32'h0, 1, 'h00, 1);
        step(1, 1, 32'h100, 0, 0, 0);
        chk("gshare_idx", int'(pi_b), 'h43);
        chk("bimodal_idx", int'(pi_a), 'h40);

        // Frozen for three cycles despite valid traffic.
        v_hold = pv_a; t_hold = pt_a; i_hold = int'(pi_a);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 32'h200, 1, 'h40, 1);
            chk("frz_valid", int'(pv_a), int'(v_hold));
            chk("frz_taken", int'(pt_a), int'(t_hold));
            chk("frz_idx",   int'(pi_a), i_hold);
        end
        step(1, 1, 32'h100, 0, 0, 0);
        chk("frz_ctr_kept", int'(pt_a), 0);

        // Train to strongly taken, then reset mid-cycle.
        step(1, 0, 32'h0, 1, 'h40, 1);
        step(1, 0, 32'h0, 1, 'h40, 1);
        step(1, 1, 32'h100, 0, 0, 0);
        chk("trained_taken", int'(pt_a), 1);
        do_reset();
        step(1, 1, 32'h100, 0, 0, 0);
        chk("post_rst_taken", int'(pt_a), 0);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(60, 67)),
                 $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
